playfield_scroll: RTL and testbench



---
 rtl/playfield_scroll.sv | 196 +++++++++++++++++++
 tb/tb_playfield_scroll.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_scroll.sv
// Playfield scroller for the cart game: shifts generator rows down the field once per
// sampling period and tracks the cart, collisions and score. Optional macro PLAYFIELD_WRAP_EN.
module playfield_scroll #(
    parameter int WIDTH = 2,
    parameter int ROWS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              left,
    input  logic              right,
    input  logic [7:0]        row_in,
    output logic [ROWS*8-1:0] field,
    output logic [2:0]        cart_col,
    output logic              gg,
    output logic [9:0]        score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [2:0] CART_HOME = 3'd3;
    localparam logic [9:0] SCORE_MAX = 10'd999;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  cnt_r;
    logic [ROWS*8-1:0] field_r;
    logic [ROWS*8-1:0] field_nxt_s;
    logic [ROWS*8-1:0] field_play_s;
    logic [2:0]        cart_r;
    logic [2:0]        cart_nxt_s;
    logic [2:0]        cart_play_s;
    logic [9:0]        score_r;
    logic [9:0]        score_nxt_s;
    logic              gg_r;
    logic              gg_nxt_s;
    logic              shift_s;
    logic              collide_s;
    logic              score_inc_s;
    logic [7:0]        bottom_old_s;
    logic [7:0]        bottom_play_s;

    function automatic logic [2:0] col_inc(input logic [2:0] col);
`ifdef PLAYFIELD_WRAP_EN
        col_inc = col + 3'd1;
`else
        if (col == 3'd7) begin
            col_inc = 3'd7;
        end else begin
            col_inc = col + 3'd1;
        end
`endif
    endfunction

    function automatic logic [2:0] col_dec(input logic [2:0] col);
`ifdef PLAYFIELD_WRAP_EN
        col_dec = col - 3'd1;
`else
        if (col == 3'd0) begin
            col_dec = 3'd0;
        end else begin
            col_dec = col - 3'd1;
        end
`endif
    endfunction

    // Shift fires on the phase where the generator has just presented a fresh row.
    assign shift_s      = (state_r == PLAY) && (cnt_r == WIDTH'(1));
    assign bottom_old_s = field_r[(ROWS-1)*8 +: 8];

    // Candidate PLAY-state field, cart and collision from next-state values.
    always_comb begin
        field_play_s = field_r;
        cart_play_s  = cart_r;
        if (shift_s) begin
            field_play_s = {field_r[(ROWS-1)*8-1:0], row_in};
        end else begin
            field_play_s = field_r;
        end
        if (left && !right) begin
            cart_play_s = col_inc(cart_r);
        end else if (right && !left) begin
            cart_play_s = col_dec(cart_r);
        end else begin
            cart_play_s = cart_r;
        end
        bottom_play_s = field_play_s[(ROWS-1)*8 +: 8];
        collide_s     = (state_r == PLAY) && bottom_play_s[cart_play_s];
        score_inc_s   = shift_s && !collide_s && (bottom_old_s != 8'd0)
                        && (score_r != SCORE_MAX);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = PLAY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PLAY: begin
                if (collide_s) begin
                    state_nxt_s = OVER;
                end else begin
                    state_nxt_s = PLAY;
                end
            end
            OVER:    state_nxt_s = OVER;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state next values for the registered outputs.
    always_comb begin
        field_nxt_s = field_r;
        cart_nxt_s  = cart_r;
        score_nxt_s = score_r;
        gg_nxt_s    = gg_r;
        case (state_r)
            IDLE: begin
                field_nxt_s = '0;
                cart_nxt_s  = CART_HOME;
                score_nxt_s = 10'd0;
                gg_nxt_s    = 1'b0;
            end
            PLAY: begin
                field_nxt_s = field_play_s;
                cart_nxt_s  = cart_play_s;
                gg_nxt_s    = collide_s;
                if (score_inc_s) begin
                    score_nxt_s = score_r + 10'd1;
                end else begin
                    score_nxt_s = score_r;
                end
            end
            OVER: begin
                field_nxt_s = field_r;
                cart_nxt_s  = cart_r;
                score_nxt_s = score_r;
                gg_nxt_s    = 1'b1;
            end
            default: begin
                field_nxt_s = '0;
                cart_nxt_s  = CART_HOME;
                score_nxt_s = 10'd0;
                gg_nxt_s    = 1'b0;
            end
        endcase
    end

    // Free-running period counter, phase-locked to the generator through the shared reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + WIDTH'(1);
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            field_r <= '0;
            cart_r  <= CART_HOME;
            score_r <= 10'd0;
            gg_r    <= 1'b0;
        end else begin
            field_r <= field_nxt_s;
            cart_r  <= cart_nxt_s;
            score_r <= score_nxt_s;
            gg_r    <= gg_nxt_s;
        end
    end

    assign field    = field_r;
    assign cart_col = cart_r;
    assign score    = score_r;
    assign gg       = gg_r;

endmodule

// File: tb/tb_playfield_scroll.sv
// Directed self-checking bench for playfield_scroll (WIDTH=2, ROWS=8).
// Expectations follow PLAYFIELD_WRAP_EN when the macro is defined.
module tb_playfield_scroll;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        left;
    logic        right;
    logic [7:0]  row_in;
    logic [63:0] field;
    logic [2:0]  cart_col;
    logic        gg;
    logic [9:0]  score;

    int checks   = 0;
    int failures = 0;

    playfield_scroll #(.WIDTH(2), .ROWS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .left     (left),
        .right    (right),
        .row_in   (row_in),
        .field    (field),
        .cart_col (cart_col),
        .gg       (gg),
        .score    (score)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the DUT out of reset at a negedge with cnt = 0.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; left = 1'b0; right = 1'b0; row_in = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (field !== 64'h0) begin failures++; $display("FAIL reset_field got=%h exp=%h", field, 64'h0); end
        checks++; if (cart_col !== 3'd3) begin failures++; $display("FAIL reset_cart got=%0d exp=3", cart_col); end
        checks++; if (gg !== 1'b0) begin failures++; $display("FAIL reset_gg got=%b exp=0", gg); end
        checks++; if (score !== 10'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        // IDLE ignores moves and rows
        row_in = 8'hff; left = 1'b1;
        cycles(1);
        left = 1'b0;
        cycles(2);
        checks++; if (field !== 64'h0) begin failures++; $display("FAIL idle_field got=%h exp=0", field); end
        checks++; if (cart_col !== 3'd3) begin failures++; $display("FAIL idle_cart got=%0d exp=3", cart_col); end
    endtask

    task automatic test_fill();
        do_reset();
        start = 1'b1; row_in = 8'h81;
        cycles(2);
        checks++; if (field !== 64'h81) begin failures++; $display("FAIL fill_row0 got=%h exp=%h", field, 64'h81); end
        cycles(4);
        checks++; if (field !== 64'h8181) begin failures++; $display("FAIL fill_row1 got=%h exp=%h", field, 64'h8181); end
        cycles(24);
        checks++; if (field !== {8{8'h81}}) begin failures++; $display("FAIL fill_full got=%h exp=%h", field, {8{8'h81}}); end
        checks++; if (gg !== 1'b0) begin failures++; $display("FAIL fill_gg got=%b exp=0", gg); end
        checks++; if (score !== 10'd0) begin failures++; $display("FAIL fill_score0 got=%0d exp=0", score); end
        cycles(4);
        checks++; if (score !== 10'd1) begin failures++; $display("FAIL fill_score1 got=%0d exp=1", score); end
    endtask

    task automatic test_game_over();
        do_reset();
        start = 1'b1; row_in = 8'h08;
        cycles(29);
        checks++; if (gg !== 1'b0) begin failures++; $display("FAIL over_pre_gg got=%b exp=0", gg); end
        cycles(1);
        checks++; if (gg !== 1'b1) begin failures++; $display("FAIL over_gg got=%b exp=1", gg); end
        checks++; if (field !== {8{8'h08}}) begin failures++; $display("FAIL over_field got=%h exp=%h", field, {8{8'h08}}); end
        checks++; if (cart_col !== 3'd3) begin failures++; $display("FAIL over_cart got=%0d exp=3", cart_col); end
        row_in = 8'hff;
        for (int i = 0; i < 20; i++) begin
            left  = i[0];
            right = i[1];
            @(negedge clk);
        end
        left = 1'b0; right = 1'b0;
        checks++; if (field !== {8{8'h08}}) begin failures++; $display("FAIL frozen_field got=%h exp=%h", field, {8{8'h08}}); end
        checks++; if (cart_col !== 3'd3) begin failures++; $display("FAIL frozen_cart got=%0d exp=3", cart_col); end
        checks++; if (score !== 10'd0) begin failures++; $display("FAIL frozen_score got=%0d exp=0", score); end
        checks++; if (gg !== 1'b1) begin failures++; $display("FAIL frozen_gg got=%b exp=1", gg); end
    endtask

    task automatic test_moves();
        logic [2:0] exp_r [6];
        logic [2:0] exp_l [8];
`ifdef PLAYFIELD_WRAP_EN
        exp_r = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5};
        exp_l = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
`else
        exp_r = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_l = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
`endif
        do_reset();
        start = 1'b1; row_in = 8'h00;
        cycles(1);
        for (int i = 0; i < 6; i++) begin
            right = 1'b1;
            @(negedge clk);
            checks++; if (cart_col !== exp_r[i]) begin failures++; $display("FAIL move_right%0d got=%0d exp=%0d", i, cart_col, exp_r[i]); end
        end
        left = 1'b1; right = 1'b1;
        cycles(1);
        right = 1'b0;
        checks++; if (cart_col !== exp_r[5]) begin failures++; $display("FAIL move_both got=%0d exp=%0d", cart_col, exp_r[5]); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (cart_col !== exp_l[i]) begin failures++; $display("FAIL move_left%0d got=%0d exp=%0d", i, cart_col, exp_l[i]); end
        end
        left = 1'b0;
    endtask

    task automatic test_move_collide();
        do_reset();
        start = 1'b1; row_in = 8'h10;
        cycles(29);
        checks++; if (gg !== 1'b0) begin failures++; $display("FAIL mcol_pre_gg got=%b exp=0", gg); end
        left = 1'b1;
        cycles(1);
        left = 1'b0;
        checks++; if (gg !== 1'b1) begin failures++; $display("FAIL mcol_gg got=%b exp=1", gg); end
        checks++; if (cart_col !== 3'd4) begin failures++; $display("FAIL mcol_cart got=%0d exp=4", cart_col); end
    endtask

    task automatic test_start_boundary();
        do_reset();
        cycles(1);
        start = 1'b1; row_in = 8'haa;
        cycles(1);
        checks++; if (field !== 64'h0) begin failures++; $display("FAIL sb_noshift got=%h exp=0", field); end
        cycles(3);
        checks++; if (field !== 64'h0) begin failures++; $display("FAIL sb_wait got=%h exp=0", field); end
        cycles(1);
        checks++; if (field !== 64'haa) begin failures++; $display("FAIL sb_first got=%h exp=%h", field, 64'haa); end
    endtask

    task automatic test_score();
        do_reset();
        start = 1'b1; row_in = 8'h81;
        cycles(2);
        for (int k = 1; k <= 15; k++) begin
            row_in = (k % 2 == 1) ? 8'h00 : 8'h81;
            cycles(4);
            if (k == 7) begin
                checks++; if (score !== 10'd0) begin failures++; $display("FAIL score_k7 got=%0d exp=0", score); end
            end else if (k == 8 || k == 9) begin
                checks++; if (score !== 10'd1) begin failures++; $display("FAIL score_k%0d got=%0d exp=1", k, score); end
            end else if (k == 15) begin
                checks++; if (score !== 10'd4) begin failures++; $display("FAIL score_k15 got=%0d exp=4", score); end
            end
        end
        checks++; if (gg !== 1'b0) begin failures++; $display("FAIL score_gg got=%b exp=0", gg); end
    endtask

    task automatic test_saturate();
        do_reset();
        start = 1'b1; row_in = 8'h81;
        cycles(2);
        for (int k = 1; k <= 1010; k++) begin
            cycles(4);
            if (k == 1005) begin
                checks++; if (score !== 10'd998) begin failures++; $display("FAIL sat_998 got=%0d exp=998", score); end
            end else if (k == 1006 || k == 1010) begin
                checks++; if (score !== 10'd999) begin failures++; $display("FAIL sat_999_k%0d got=%0d exp=999", k, score); end
            end
        end
    endtask

    task automatic test_reset_midgame();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (field !== 64'h0) begin failures++; $display("FAIL async_field got=%h exp=0", field); end
        checks++; if (cart_col !== 3'd3) begin failures++; $display("FAIL async_cart got=%0d exp=3", cart_col); end
        checks++; if (score !== 10'd0) begin failures++; $display("FAIL async_score got=%0d exp=0", score); end
        checks++; if (gg !== 1'b0) begin failures++; $display("FAIL async_gg got=%b exp=0", gg); end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; row_in = 8'hff;
        cycles(12);
        checks++; if (field !== 64'h0) begin failures++; $display("FAIL async_idle got=%h exp=0", field); end
        start = 1'b1;
        cycles(2);
        checks++; if (field !== 64'hff) begin failures++; $display("FAIL async_resume got=%h exp=%h", field, 64'hff); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; left = 1'b0; right = 1'b0; row_in = 8'h00;
        test_reset();
        test_fill();
        test_game_over();
        test_moves();
        test_move_collide();
        test_start_boundary();
        test_score();
        test_saturate();
        test_reset_midgame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
